dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Controller for the write-through, no-write-allocate, direct-mapped L1 data cache. It sits between the core's data-memory port and the system memory bus. It drives one `cache_set` instance for lookup, word writes and fills, and owns a small posted write buffer. Read misses are serviced by a single-beat memory read followed by a fill; the original request is then replayed as a hit.

## Interface
- `CACHE_SET_DEPTH`, default 32: lines in the set; passed to `cache_set`.
- `WB_DEPTH`, default 2: write buffer entries; power of 2, ≥ 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `core_read`  in  1  read request; held until accepted.
- `core_write`  in  1  write request; held until accepted.
- `core_address`  in  32  byte address; bits [1:0] ignored.
- `core_writedata`  in  32  write data.
- `core_byteenable`  in  4  byte lanes.
- `core_waitrequest`  out  1  request not accepted this cycle.
- `core_readdata`  out  32  read data.
- `core_readdatavalid`  out  1  read data valid.
- `mem_read`  out  1  memory read.
- `mem_write`  out  1  memory write.
- `mem_address`  out  32  word-aligned address.
- `mem_writedata`  out  32  write data.
- `mem_byteenable`  out  4  byte lanes.
- `mem_waitrequest`  in  1  memory stall.
- `mem_readdata`  in  32  read data.
- `mem_readdatavalid`  in  1  read data valid; at least 1 cycle after acceptance.

## Operation
- FSM states: IDLE, MERGE, DRAIN, MISS_REQ, MISS_RESP.
- `cache_set` wiring:
  - `address` = `core_address`.
  - `set_nru` / `clr_nru` tied 0; `nru` unused.
  - `dirty` and `dirty_data` unused, because the cache is write-through.
- IDLE, `core_read` and hit: accept (`core_waitrequest`=0). `core_readdatavalid`=1 the next cycle, with `core_readdata` = set readdata.
- IDLE, `core_read` and miss: not accepted.
  - Go to DRAIN if the write buffer is non-empty, else to MISS_REQ.
- DRAIN: wait for the buffer to empty, then go to MISS_REQ.
- MISS_REQ: `mem_read`=1, `mem_address`={`core_address`[31:2],2'b00}, `mem_byteenable`=4'hF. Hold until `!mem_waitrequest`, then go to MISS_RESP.
- MISS_RESP: on `mem_readdatavalid`, pulse `fill` with `fill_address`=`core_address` and `fill_data`=`mem_readdata`, then go to IDLE. The held read then hits.
- IDLE, `core_write`, buffer full: not accepted.
- IDLE, `core_write`, buffer not full, and (miss or `core_byteenable`==4'hF):
  - Accept and push {address, data, byteenable}.
  - Drive set `write`=1; the set updates only on a hit.
- IDLE, `core_write`, hit, partial byteenable, buffer not full: not accepted; go to MERGE.
- MERGE (set readdata now valid):
  - Build merged word: byte lanes from `core_writedata` where enabled, else from readdata.
  - Pulse `fill` with the merged word, push the original request, accept, return to IDLE.
- Reads and writes asserted together is illegal; read has priority.
- Write buffer behaviour:
  - FIFO; the head drives `mem_write` whenever non-empty and the state is not MISS_REQ/MISS_RESP.
  - Pop on `mem_write & !mem_waitrequest`.
  - Simultaneous push and pop leaves the count unchanged.
  - `mem_read` and `mem_write` are never both 1.
- Reset:
  - State returns to IDLE and the buffer empties; `mem_read`/`mem_write`/`core_readdatavalid`=0 and `core_waitrequest`=1.
  - A `mem_readdatavalid` arriving after reset mid-miss is ignored.

## Timing
- Read hit latency: data 1 cycle after acceptance.
- Clean read miss, with memory accept latency A and data latency L, takes, counted from first request cycle:
  - IDLE 1 cycle, MISS_REQ A+1 cycles, MISS_RESP L cycles.
  - Then acceptance in IDLE, and data 1 cycle later.
- Full-word write: accepted in the request cycle if the buffer is not full.
- Partial write hit: accepted on the 2nd cycle (MERGE).
- Buffer count updates at the clock edge; `core_waitrequest` is combinational from state, hit, byteenable and the full flag.

## Structure
- Shared package `dcache_pkg`:
  - State enum.
  - Write buffer entry struct {addr[31:0], data[31:0], be[3:0]}.
  - Byte-merge function.
- Sub-module `cache_wbuf`: parameterised FIFO of `dcache_pkg` entries, with `push`/`pop`/`full`/`empty` and head outputs.
- `cache_set` instantiated with `CACHE_LINE_SIZE`=4 and `NRU_LOGIC`=0.

## Test plan
- Cold read 0x100 with memory returning 0xDEADBEEF (A=0, L=2):
  - One `mem_read` at 0x100.
  - `fill`, then `core_readdatavalid` with 0xDEADBEEF.
  - Repeat read: hit, data 1 cycle later, no `mem_read`.
- Full write 0x11223344 to cached 0x100:
  - Accepted same cycle.
  - `mem_write` 0x100 / 0x11223344 / 4'hF.
  - Read back 0x11223344 without a memory read.
- Partial write be=4'b0010, data 0x0000AA00, to line holding 0xDEADBEEF:
  - Accepted after MERGE.
  - Cache reads 0xDEADAAEF.
  - Memory sees be=4'b0010.
- Three back-to-back writes with `mem_waitrequest` held high:
  - First two accepted.
  - Third stalls until the first pop.
  - Memory order preserved.
- Read miss with 2 buffered writes: no `mem_read` until both writes are accepted by memory; never both strobes.
- Assert `rst` during MISS_RESP:
  - Outputs return to reset values.
  - A late `mem_readdatavalid` causes no fill.
  - A subsequent read misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types for the L1 data cache controller: FSM states, write buffer entries
// and the byte-lane merge used when a partial write hits a cached line.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MERGE,
    DRAIN,
    MISS_REQ,
    MISS_RESP
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wb_entry_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[b*8 +: 8] = be[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cache_set.sv
// Direct-mapped cache set: combinational tag compare, registered data read,
// byte-lane writes that land only on a hit, and whole-line fills.
module cache_set #(
  parameter int CACHE_SET_DEPTH = 32,
  parameter int CACHE_LINE_SIZE = 4,
  parameter int NRU_LOGIC       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  address,
  output logic                         hit,
  output logic [8*CACHE_LINE_SIZE-1:0] readdata,
  input  logic                         write,
  input  logic [8*CACHE_LINE_SIZE-1:0] writedata,
  input  logic [CACHE_LINE_SIZE-1:0]   byteenable,
  input  logic                         fill,
  input  logic [31:0]                  fill_address,
  input  logic [8*CACHE_LINE_SIZE-1:0] fill_data,
  output logic                         dirty,
  output logic [8*CACHE_LINE_SIZE-1:0] dirty_data,
  input  logic                         set_nru,
  input  logic                         clr_nru,
  output logic                         nru
);
  localparam int LW = 8 * CACHE_LINE_SIZE;
  localparam int OW = $clog2(CACHE_LINE_SIZE);
  localparam int IW = $clog2(CACHE_SET_DEPTH);
  localparam int TW = 32 - OW - IW;

  logic [LW-1:0]              data_ram [CACHE_SET_DEPTH];
  logic [TW-1:0]              tag_reg  [CACHE_SET_DEPTH];
  logic [CACHE_SET_DEPTH-1:0] valid_reg, dirty_reg;
  logic [IW-1:0]              idx, fill_idx, wr_idx;
  logic                       wr_en;
  logic [LW-1:0]              wr_data;
  logic [CACHE_LINE_SIZE-1:0] wr_be;
  logic                       unused_offsets;

  assign idx            = address[OW +: IW];
  assign fill_idx       = fill_address[OW +: IW];
  assign hit            = valid_reg[idx] && (tag_reg[idx] == address[31 -: TW]);
  assign unused_offsets = ^{address[OW-1:0], fill_address[OW-1:0]};

  // A fill always wins the single write port; core writes only land on a hit.
  always_comb begin
    wr_en   = fill || (write && hit);
    wr_idx  = fill ? fill_idx : idx;
    wr_data = fill ? fill_data : writedata;
    wr_be   = fill ? '1 : byteenable;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < CACHE_LINE_SIZE; b++) begin
      if (wr_en && wr_be[b]) data_ram[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
    readdata <= data_ram[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (fill) begin
      valid_reg[fill_idx] <= 1'b1;
      dirty_reg[fill_idx] <= 1'b0;
    end else if (write && hit) begin
      dirty_reg[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) tag_reg[fill_idx] <= fill_address[31 -: TW];
  end

  assign dirty      = valid_reg[idx] && dirty_reg[idx];
  assign dirty_data = readdata;

  generate
    if (NRU_LOGIC != 0) begin : g_nru
      logic [CACHE_SET_DEPTH-1:0] nru_reg;
      always_ff @(posedge clk) begin
        if (rst)          nru_reg      <= '0;
        else if (clr_nru) nru_reg[idx] <= 1'b0;
        else if (set_nru) nru_reg[idx] <= 1'b1;
      end
      assign nru = nru_reg[idx];
    end else begin : g_no_nru
      logic unused_nru;
      assign unused_nru = set_nru ^ clr_nru;
      assign nru        = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/dcache_wbuf.sv
// Posted write buffer: small FIFO of {addr, data, be} entries whose head is
// presented combinationally to the memory bus.
module cache_wbuf
  import dcache_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_COUNT = DEPTH[PW:0];

  wb_entry_t     entries [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_push, do_pop;

  assign full    = (count_reg == DEPTH_COUNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = entries[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-through, no-write-allocate L1 data cache controller: hit/miss handling,
// partial-write merge, and a posted write buffer in front of the memory bus.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int CACHE_SET_DEPTH = 32,
  parameter int WB_DEPTH        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_read,
  input  logic        core_write,
  input  logic [31:0] core_address,
  input  logic [31:0] core_writedata,
  input  logic [3:0]  core_byteenable,
  output logic        core_waitrequest,
  output logic [31:0] core_readdata,
  output logic        core_readdatavalid,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid
);
  state_t      state_reg;
  logic        hit, set_write, fill, partial, rd_accept, wr_accept;
  logic [31:0] set_readdata, fill_data;
  logic        wb_pop, wb_full, wb_empty;
  wb_entry_t   wb_in, wb_head;
  logic        nru, dirty;
  logic [31:0] dirty_data;
  logic        unused_set;

  assign partial       = (core_byteenable != 4'hF);
  assign core_readdata = set_readdata;
  assign unused_set    = ^{nru, dirty, dirty_data};

  always_comb begin
    rd_accept = !rst && (state_reg == IDLE) && core_read && hit;
    // A partial write that hits must first see the line's old bytes in MERGE.
    wr_accept = !rst && (((state_reg == IDLE) && core_write && !core_read && !wb_full
                          && (!hit || !partial))
                         || (state_reg == MERGE));
    core_waitrequest = !(rd_accept || wr_accept);
    set_write        = wr_accept && (state_reg == IDLE);
    fill             = !rst && (((state_reg == MISS_RESP) && mem_readdatavalid)
                                || (state_reg == MERGE));
    fill_data        = (state_reg == MERGE)
                       ? merge_bytes(set_readdata, core_writedata, core_byteenable)
                       : mem_readdata;
    wb_in            = '{addr: {core_address[31:2], 2'b00}, data: core_writedata,
                         be: core_byteenable};
    mem_read         = !rst && (state_reg == MISS_REQ);
    mem_write        = !rst && !wb_empty && (state_reg != MISS_REQ)
                       && (state_reg != MISS_RESP);
    wb_pop           = mem_write && !mem_waitrequest;
    mem_address      = mem_read ? {core_address[31:2], 2'b00} : wb_head.addr;
    mem_writedata    = wb_head.data;
    mem_byteenable   = mem_read ? 4'hF : wb_head.be;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      core_readdatavalid <= 1'b0;
    end else begin
      core_readdatavalid <= rd_accept;
      case (state_reg)
        IDLE: begin
          if (core_read) begin
            if (!hit) state_reg <= wb_empty ? MISS_REQ : DRAIN;
          end else if (core_write && hit && partial && !wb_full) begin
            state_reg <= MERGE;
          end
        end
        MERGE:     state_reg <= IDLE;
        DRAIN:     if (wb_empty) state_reg <= MISS_REQ;
        MISS_REQ:  if (!mem_waitrequest) state_reg <= MISS_RESP;
        MISS_RESP: if (mem_readdatavalid) state_reg <= IDLE;
        default:   state_reg <= IDLE;
      endcase
    end
  end

  cache_set #(
    .CACHE_SET_DEPTH(CACHE_SET_DEPTH),
    .CACHE_LINE_SIZE(4),
    .NRU_LOGIC      (0)
  ) u_set (
    .clk         (clk),
    .rst         (rst),
    .address     (core_address),
    .hit         (hit),
    .readdata    (set_readdata),
    .write       (set_write),
    .writedata   (core_writedata),
    .byteenable  (core_byteenable),
    .fill        (fill),
    .fill_address(core_address),
    .fill_data   (fill_data),
    .dirty       (dirty),
    .dirty_data  (dirty_data),
    .set_nru     (1'b0),
    .clr_nru     (1'b0),
    .nru         (nru)
  );

  cache_wbuf #(
    .DEPTH(WB_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_accept),
    .push_entry(wb_in),
    .pop       (wb_pop),
    .head      (wb_head),
    .full      (wb_full),
    .empty     (wb_empty)
  );

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a negedge memory responder with configurable
// read latency, plus one task per scenario with hand-computed expectations.
`timescale 1ns/1ps
module tb_dcache_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        core_read = 1'b0, core_write = 1'b0;
  logic [31:0] core_address = '0, core_writedata = '0;
  logic [3:0]  core_byteenable = '0;
  logic        core_waitrequest, core_readdatavalid;
  logic [31:0] core_readdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest = 1'b0, mem_readdatavalid = 1'b0;
  logic [31:0] mem_readdata = '0;

  int checks = 0, passed = 0;

  dcache_ctrl #(.CACHE_SET_DEPTH(32), .WB_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .core_read(core_read), .core_write(core_write), .core_address(core_address),
    .core_writedata(core_writedata), .core_byteenable(core_byteenable),
    .core_waitrequest(core_waitrequest), .core_readdata(core_readdata),
    .core_readdatavalid(core_readdatavalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          seq;
  } wr_rec_t;

  wr_rec_t     wr_log[$];
  logic [31:0] mem_img [bit [31:0]];
  int          lat = 2, pend = 0, seq = 0, rd_cnt = 0, rd_seq = 0, both_cnt = 0;
  logic [31:0] rd_addr = '0, pend_data = '0;

  // Memory responder: a handshake seen at a negedge completes at the next posedge;
  // read data comes back lat cycles after acceptance.
  always @(negedge clk) begin
    logic [31:0] w;
    mem_readdatavalid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata      = pend_data;
      end
    end
    if (mem_read && mem_write) both_cnt++;
    if (mem_read && !mem_waitrequest) begin
      seq++; rd_cnt++; rd_seq = seq; rd_addr = mem_address; pend = lat;
      pend_data = mem_img.exists(mem_address) ? mem_img[mem_address] : 32'h0;
    end
    if (mem_write && !mem_waitrequest) begin
      seq++;
      wr_log.push_back('{mem_address, mem_writedata, mem_byteenable, seq});
      w = mem_img.exists(mem_address) ? mem_img[mem_address] : 32'h0;
      for (int b = 0; b < 4; b++) if (mem_byteenable[b]) w[b*8 +: 8] = mem_writedata[b*8 +: 8];
      mem_img[mem_address] = w;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drivers start and end 1ns after a rising edge; outputs are sampled at negedges.
  task automatic core_rd(input logic [31:0] a, output logic [31:0] d, output int acc,
                         output bit ok, output bit rdv);
    core_read = 1'b1; core_address = a; acc = 0; ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); acc++;
      if (!core_waitrequest) ok = 1'b1;
      @(posedge clk); #1;
    end
    core_read = 1'b0;
    @(negedge clk); rdv = core_readdatavalid; d = core_readdata;
    @(posedge clk); #1;
    $display("rd  addr=%h data=%h accept_cycles=%0d", a, d, acc);
  endtask

  task automatic core_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         output int acc, output bit ok);
    core_write = 1'b1; core_address = a; core_writedata = d; core_byteenable = be;
    acc = 0; ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); acc++;
      if (!core_waitrequest) ok = 1'b1;
      @(posedge clk); #1;
    end
    core_write = 1'b0;
    $display("wr  addr=%h data=%h be=%b accept_cycles=%0d", a, d, be, acc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (core_waitrequest !== 1'b1) $display("FAIL rst_waitreq: got %b want 1", core_waitrequest); else passed++;
    checks++; if (mem_read !== 1'b0) $display("FAIL rst_mem_read: got %b want 0", mem_read); else passed++;
    checks++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write: got %b want 0", mem_write); else passed++;
    checks++; if (core_readdatavalid !== 1'b0) $display("FAIL rst_rdv: got %b want 0", core_readdatavalid); else passed++;
    @(posedge clk); #1; rst = 1'b0;
    tick(1);
  endtask

  task automatic test_cold_read();
    logic [31:0] d; int acc, r0; bit ok, rdv;
    lat = 2; mem_waitrequest = 1'b0; r0 = rd_cnt;
    core_rd(32'h100, d, acc, ok, rdv);
    checks++; if (!ok || acc !== 5) $display("FAIL cold_accept: ok=%b cycles=%0d want 5", ok, acc); else passed++;
    checks++; if (rd_cnt - r0 !== 1) $display("FAIL cold_mem_reads: got %0d want 1", rd_cnt - r0); else passed++;
    checks++; if (rd_addr !== 32'h100) $display("FAIL cold_mem_addr: got %h want 00000100", rd_addr); else passed++;
    checks++; if (rdv !== 1'b1 || d !== 32'hDEADBEEF) $display("FAIL cold_data: rdv=%b data=%h want 1/deadbeef", rdv, d); else passed++;
    r0 = rd_cnt;
    core_rd(32'h100, d, acc, ok, rdv);
    checks++; if (!ok || acc !== 1) $display("FAIL hit_accept: ok=%b cycles=%0d want 1", ok, acc); else passed++;
    checks++; if (rdv !== 1'b1 || d !== 32'hDEADBEEF) $display("FAIL hit_data: rdv=%b data=%h want 1/deadbeef", rdv, d); else passed++;
    checks++; if (rd_cnt !== r0) $display("FAIL hit_no_mem_read: got %0d reads want 0", rd_cnt - r0); else passed++;
  endtask

  task automatic test_partial_write();
    logic [31:0] d; int acc, r0; bit ok, rdv;
    wr_log.delete(); r0 = rd_cnt;
    core_wr(32'h100, 32'h0000AA00, 4'b0010, acc, ok);
    checks++; if (!ok || acc !== 2) $display("FAIL partial_accept: ok=%b cycles=%0d want 2", ok, acc); else passed++;
    tick(3);
    checks++;
    if (wr_log.size() !== 1) $display("FAIL partial_mem_count: got %0d want 1", wr_log.size());
    else if (wr_log[0].addr !== 32'h100 || wr_log[0].data !== 32'h0000AA00 || wr_log[0].be !== 4'b0010)
      $display("FAIL partial_mem_write: got %h/%h/%b want 00000100/0000aa00/0010", wr_log[0].addr, wr_log[0].data, wr_log[0].be);
    else passed++;
    core_rd(32'h100, d, acc, ok, rdv);
    checks++; if (!ok || acc !== 1 || rdv !== 1'b1 || d !== 32'hDEADAAEF) $display("FAIL partial_readback: cycles=%0d data=%h want 1/deadaaef", acc, d); else passed++;
    checks++; if (rd_cnt !== r0) $display("FAIL partial_no_mem_read: got %0d reads want 0", rd_cnt - r0); else passed++;
  endtask

  task automatic test_full_write();
    logic [31:0] d; int acc, r0; bit ok, rdv;
    wr_log.delete(); r0 = rd_cnt;
    core_wr(32'h100, 32'h11223344, 4'hF, acc, ok);
    checks++; if (!ok || acc !== 1) $display("FAIL full_accept: ok=%b cycles=%0d want 1", ok, acc); else passed++;
    tick(3);
    checks++;
    if (wr_log.size() !== 1) $display("FAIL full_mem_count: got %0d want 1", wr_log.size());
    else if (wr_log[0].addr !== 32'h100 || wr_log[0].data !== 32'h11223344 || wr_log[0].be !== 4'hF)
      $display("FAIL full_mem_write: got %h/%h/%b want 00000100/11223344/1111", wr_log[0].addr, wr_log[0].data, wr_log[0].be);
    else passed++;
    core_rd(32'h100, d, acc, ok, rdv);
    checks++; if (!ok || acc !== 1 || rdv !== 1'b1 || d !== 32'h11223344) $display("FAIL full_readback: cycles=%0d data=%h want 1/11223344", acc, d); else passed++;
    checks++; if (rd_cnt !== r0) $display("FAIL full_no_mem_read: got %0d reads want 0", rd_cnt - r0); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [3];
    int acc, stalls; bit ok;
    exp_d[0] = 32'hA0A00001; exp_d[1] = 32'hB0B00002; exp_d[2] = 32'hC0C00003;
    wr_log.delete(); mem_waitrequest = 1'b1;
    core_wr(32'h400, exp_d[0], 4'hF, acc, ok);
    checks++; if (!ok || acc !== 1) $display("FAIL b2b_first: ok=%b cycles=%0d want 1", ok, acc); else passed++;
    core_wr(32'h404, exp_d[1], 4'hF, acc, ok);
    checks++; if (!ok || acc !== 1) $display("FAIL b2b_second: ok=%b cycles=%0d want 1", ok, acc); else passed++;
    core_write = 1'b1; core_address = 32'h408; core_writedata = exp_d[2]; core_byteenable = 4'hF;
    stalls = 0;
    repeat (4) begin
      @(negedge clk); if (core_waitrequest) stalls++;
      @(posedge clk); #1;
    end
    checks++; if (stalls !== 4) $display("FAIL b2b_third_stall: stalled %0d of 4 cycles", stalls); else passed++;
    mem_waitrequest = 1'b0;
    core_wr(32'h408, exp_d[2], 4'hF, acc, ok);
    checks++; if (!ok || acc !== 2) $display("FAIL b2b_third_accept: ok=%b cycles=%0d want 2", ok, acc); else passed++;
    tick(4);
    checks++; if (wr_log.size() !== 3) $display("FAIL b2b_mem_count: got %0d want 3", wr_log.size()); else passed++;
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[i].addr !== 32'h400 + 32'(4*i) || wr_log[i].data !== exp_d[i])
        $display("FAIL b2b_order_%0d: got %h/%h want %h/%h", i, wr_log[i].addr, wr_log[i].data, 32'h400 + 32'(4*i), exp_d[i]);
      else passed++;
    end
  endtask

  task automatic test_miss_drain();
    logic [31:0] d; int acc, early; bit ok, rdv;
    wr_log.delete(); mem_waitrequest = 1'b1;
    core_wr(32'h500, 32'h55550000, 4'hF, acc, ok);
    core_wr(32'h504, 32'h55550004, 4'hF, acc, ok);
    core_read = 1'b1; core_address = 32'h200; early = 0;
    repeat (3) begin
      @(negedge clk); if (mem_read) early++;
      @(posedge clk); #1;
    end
    checks++; if (early !== 0) $display("FAIL drain_early_read: mem_read seen %0d cycles want 0", early); else passed++;
    mem_waitrequest = 1'b0;
    core_rd(32'h200, d, acc, ok, rdv);
    checks++; if (!ok || rdv !== 1'b1 || d !== 32'hCAFEF00D) $display("FAIL drain_read_data: ok=%b data=%h want cafef00d", ok, d); else passed++;
    checks++;
    if (wr_log.size() !== 2) $display("FAIL drain_mem_count: got %0d want 2", wr_log.size());
    else if (wr_log[0].addr !== 32'h500 || wr_log[1].addr !== 32'h504 || wr_log[1].seq > rd_seq)
      $display("FAIL drain_order: writes %h,%h seq %0d read seq %0d", wr_log[0].addr, wr_log[1].addr, wr_log[1].seq, rd_seq);
    else passed++;
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] d; int acc, r0; bit ok, rdv;
    lat = 6; core_read = 1'b1; core_address = 32'h300;
    tick(3);
    rst = 1'b1; core_read = 1'b0;
    @(negedge clk);
    checks++; if (core_waitrequest !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0)
      $display("FAIL midrst_outputs: waitreq=%b mem_read=%b mem_write=%b want 1/0/0", core_waitrequest, mem_read, mem_write); else passed++;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (core_readdatavalid !== 1'b0 || mem_read !== 1'b0)
      $display("FAIL midrst_after: rdv=%b mem_read=%b want 0/0", core_readdatavalid, mem_read); else passed++;
    tick(6);
    lat = 2; r0 = rd_cnt;
    core_rd(32'h300, d, acc, ok, rdv);
    checks++; if (!ok || acc !== 5 || rd_cnt - r0 !== 1) $display("FAIL midrst_remiss: cycles=%0d reads=%0d want 5/1", acc, rd_cnt - r0); else passed++;
    checks++; if (rdv !== 1'b1 || d !== 32'h12345678) $display("FAIL midrst_data: rdv=%b data=%h want 1/12345678", rdv, d); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mem_img[32'h100] = 32'hDEADBEEF;
    mem_img[32'h200] = 32'hCAFEF00D;
    mem_img[32'h300] = 32'h12345678;
    #1;
    test_reset();
    test_cold_read();
    test_partial_write();
    test_full_write();
    test_back_to_back();
    test_miss_drain();
    test_reset_mid_miss();
    checks++; if (both_cnt !== 0) $display("FAIL both_strobes: seen %0d cycles want 0", both_cnt); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
